// File: rtl/prewish_multi_blinky.sv
// Multi-channel LED pattern blinker behind a Wishbone-subset register port.
// Each channel rotates its own mask onto one LED, advancing on a shared prescaler tick.
module prewish_multi_blinky #(
    parameter  int NUM_CH    = 4,
    parameter  int MASK_BITS = 8,
    parameter  int DIV_BITS  = 22,
    localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic                 WE_I,
    input  logic [CH_BITS:0]     ADR_I,
    input  logic [MASK_BITS-1:0] DAT_I,
    output logic [MASK_BITS-1:0] DAT_O,
    output logic                 ACK_O,
    output logic                 o_alive,
    output logic [NUM_CH-1:0]    o_led
);

    localparam int STEP_BITS = $clog2(MASK_BITS + 1);
    localparam logic [STEP_BITS-1:0] STEP_FULL = STEP_BITS'(MASK_BITS);

    typedef enum logic {
        REG_MASK = 1'b0,
        REG_CTRL = 1'b1
    } reg_sel_e;

    logic [DIV_BITS-1:0]  div_q;
    logic                 tick;
    logic [MASK_BITS-1:0] mask_q [NUM_CH];
    logic [STEP_BITS-1:0] step_q [NUM_CH];
    logic [NUM_CH-1:0]    en_q;
    logic [NUM_CH-1:0]    oneshot_q;
    logic [NUM_CH-1:0]    done_q;

    logic                 accept;
    logic [CH_BITS-1:0]   bus_ch;
    reg_sel_e             bus_reg;
    logic [NUM_CH-1:0]    ch_hit;
    logic [NUM_CH-1:0]    wr_hit;
    logic [MASK_BITS-1:0] rd_data;

    assign tick    = &div_q;
    assign o_alive = div_q[DIV_BITS-1];

    // A held strobe is acked every other cycle because a raised ACK_O blocks the next accept.
    assign accept  = STB_I & ~ACK_O;
    assign bus_ch  = ADR_I[CH_BITS-1:0];
    assign bus_reg = reg_sel_e'(ADR_I[CH_BITS]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ch_hit  = '0;
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus_ch == CH_BITS'(c)) begin
                ch_hit[c] = 1'b1;
                rd_data   = (bus_reg == REG_CTRL)
                          ? MASK_BITS'({done_q[c], oneshot_q[c], en_q[c]})
                          : mask_q[c];
            end
        end
    end

    // Unmatched channel indices leave ch_hit empty: writes drop, reads return 0.
    assign wr_hit = ch_hit & {NUM_CH{accept & WE_I}};

    always_ff @(posedge CLK_I or posedge RST_I) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST_I) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_BITS'(1);
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ACK_O <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK_O <= accept;
            DAT_O <= (accept && !WE_I) ? rd_data : '0;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            // NOTE: the per-channel arrays are plain registers, not RAM, so they take the async reset too.
            for (int c = 0; c < NUM_CH; c++) begin
                mask_q[c] <= '0;
                step_q[c] <= '0;
            end
            en_q      <= '0;
            oneshot_q <= '0;
            done_q    <= '0;
            o_led     <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c]) begin
                    // A bus write to this channel wins over a coincident tick.
                    if (bus_reg == REG_CTRL) begin
                        en_q[c]      <= DAT_I[0];
                        oneshot_q[c] <= DAT_I[1];
                        done_q[c]    <= 1'b0;
                    end else begin
                        mask_q[c] <= DAT_I;
                        step_q[c] <= '0;
                        done_q[c] <= 1'b0;
                        o_led[c]  <= 1'b0;
                    end
                end else if (!en_q[c]) begin
                    o_led[c] <= 1'b0;
                end else if (tick && !done_q[c]) begin
                    if (oneshot_q[c] && (step_q[c] == STEP_FULL)) begin
                        o_led[c]  <= 1'b0;
                        done_q[c] <= 1'b1;
                    end else begin
                        o_led[c]  <= mask_q[c][MASK_BITS-1];
                        mask_q[c] <= {mask_q[c][MASK_BITS-2:0], mask_q[c][MASK_BITS-1]};
                        if (step_q[c] != STEP_FULL) begin
                            step_q[c] <= step_q[c] + STEP_BITS'(1);
                        end
                    end
                end
            end
        end
    end

endmodule
